v_hier_deser: RTL and testbench

//  Downstream consumer of the single-bit q output of v_hier_subsub.

---
 rtl/v_hier_deser_if.sv | 24 ++
 rtl/v_hier_deser.sv | 129 ++++++++++++
 tb/tb_v_hier_deser.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/v_hier_deser_if.sv
// Serial-in / word-out bundle between a bit producer, the deserializer and the word consumer.
// The master side is the environment; the slave side is the deserializer.
interface v_hier_deser_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             bit_in;
  logic             bit_vld;
  logic             word_rdy;
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  modport master (
    output bit_in, bit_vld, word_rdy,
    input  word_out, word_vld, bit_cnt, overrun
  );

  modport slave (
    input  bit_in, bit_vld, word_rdy,
    output word_out, word_vld, bit_cnt, overrun
  );
endinterface

// File: rtl/v_hier_deser.sv
// Serial-to-parallel deserializer with one output word of buffering and a sticky overrun flag.
// A full shift register waits in STALL until the buffered word is accepted.
module v_hier_deser #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  v_hier_deser_if.slave    bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             vld_q,   vld_d;
  logic             ovr_q,   ovr_d;

  logic [WIDTH-1:0] shifted;

  // New bit enters at the end opposite to where the first bit must finally sit.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  assign shifted = shift_in(shift_q, bus.bit_in);

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    if (clr) begin
      state_d = COLLECT;
      shift_d = '0;
      cnt_d   = '0;
      word_d  = '0;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (vld_q && bus.word_rdy) vld_d = 1'b0;

      unique case (state_q)
        COLLECT: begin
          if (bus.bit_vld) begin
            if (cnt_q < CNT_LAST) begin
              shift_d = shifted;
              cnt_d   = cnt_q + CNT_ONE;
            end else if (!vld_q || bus.word_rdy) begin
              word_d  = shifted;
              vld_d   = 1'b1;
              shift_d = '0;
              cnt_d   = '0;
            end else begin
              shift_d = shifted;
              cnt_d   = CNT_FULL;
              state_d = STALL;
            end
          end
        end

        STALL: begin
          if (bus.word_rdy) begin
            // Buffered word leaves and the full shift register replaces it in the same edge.
            word_d  = shift_q;
            vld_d   = 1'b1;
            state_d = COLLECT;
            if (bus.bit_vld) begin
              shift_d = shift_in('0, bus.bit_in);
              cnt_d   = CNT_ONE;
            end else begin
              shift_d = '0;
              cnt_d   = '0;
            end
          end else if (bus.bit_vld) begin
            ovr_d = 1'b1;
          end
        end

        default: state_d = COLLECT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.word_out = word_q;
  assign bus.word_vld = vld_q;
  assign bus.bit_cnt  = cnt_q;
  assign bus.overrun  = ovr_q;

  a_cnt_max:   assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_FULL);
  a_full_only: assert property (@(posedge clk) disable iff (rst) (cnt_q == CNT_FULL) == (state_q == STALL));
  a_stall_vld: assert property (@(posedge clk) disable iff (rst) (state_q == STALL) |-> vld_q);

endmodule

// File: tb/tb_v_hier_deser.sv
// Self-checking bench for v_hier_deser: LSB-first and MSB-first instances driven in lockstep.
// Directed table, hand-written corner sequences, then random traffic against a queue-based model.
module tb_v_hier_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  v_hier_deser_if #(.WIDTH(W), .CNT_W(4)) if0 ();
  v_hier_deser_if #(.WIDTH(W), .CNT_W(4)) if1 ();

  v_hier_deser #(.WIDTH(W), .CNT_W(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .bus(if0)
  );
  v_hier_deser #(.WIDTH(W), .CNT_W(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .bus(if1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required $finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic vld, input logic b, input logic rdy, input logic c);
    if0.bit_vld = vld; if1.bit_vld = vld;
    if0.bit_in  = b;   if1.bit_in  = b;
    if0.word_rdy = rdy; if1.word_rdy = rdy;
    clr = c;
  endtask

  // One clock: apply inputs, take the edge, settle just after it.
  task automatic cyc(input logic vld, input logic b, input logic rdy, input logic c);
    drive(vld, b, rdy, c);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input logic v, input logic [3:0] cnt, input logic ovr);
    check({tag, ".word_lsb"}, 32'(if0.word_out), 32'(w0));
    check({tag, ".word_msb"}, 32'(if1.word_out), 32'(w1));
    check({tag, ".vld"},      32'(if0.word_vld), 32'(v));
    check({tag, ".cnt"},      32'(if0.bit_cnt),  32'(cnt));
    check({tag, ".ovr"},      32'(if0.overrun),  32'(ovr));
  endtask

  typedef struct {
    logic       vld, b, rdy, c;
    logic       exp_vld;
    logic [7:0] exp_w0, exp_w1;
    logic [3:0] exp_cnt;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl [10];

  // Reference model: received bits held as a queue; a word is just that queue packed by index.
  bit         mq[$];
  logic       m_vld;
  logic [7:0] m_w0, m_w1;
  logic       m_ovr;

  task automatic model_clear();
    mq.delete();
    m_vld = 1'b0; m_w0 = '0; m_w1 = '0; m_ovr = 1'b0;
  endtask

  task automatic model_load();
    for (int i = 0; i < W; i++) begin
      m_w0[i]       = mq[i];
      m_w1[W-1-i]   = mq[i];
    end
    m_vld = 1'b1;
    mq.delete();
  endtask

  task automatic model_step(input logic vld, input logic b, input logic rdy, input logic c);
    logic free;
    if (c) begin
      model_clear();
    end else if (mq.size() == W) begin
      if (rdy) begin
        model_load();
        if (vld) mq.push_back(b);
      end else if (vld) begin
        m_ovr = 1'b1;
      end
    end else begin
      free = !m_vld || rdy;
      if (m_vld && rdy) m_vld = 1'b0;
      if (vld) begin
        mq.push_back(b);
        if (mq.size() == W && free) model_load();
      end
    end
  endtask

  task automatic send_byte_lsb(input logic [7:0] v, input logic rdy);
    for (int i = 0; i < W; i++) cyc(1'b1, v[i], rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] seq;
    int         rdy_pct;
    logic       rv, rb, rr, rc;

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("reset_async", 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("reset_idle", 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);

    // Bits 1,0,1,1,0,0,0,0 with the consumer always ready.
    seq = 8'b0000_1101;
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{vld: 1'b1, b: seq[i], rdy: 1'b1, c: 1'b0,
                 exp_vld: (i == 7), exp_w0: (i == 7) ? 8'h0D : 8'h00,
                 exp_w1: (i == 7) ? 8'hB0 : 8'h00,
                 exp_cnt: (i == 7) ? 4'd0 : 4'(i + 1), exp_ovr: 1'b0};
    end
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0D, 8'hB0, 4'd0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0D, 8'hB0, 4'd0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].vld, tbl[i].b, tbl[i].rdy, tbl[i].c);
      check_all($sformatf("tbl%0d", i), tbl[i].exp_w0, tbl[i].exp_w1,
                tbl[i].exp_vld, tbl[i].exp_cnt, tbl[i].exp_ovr);
    end

    // Stall, overrun, release with consumer held off.
    send_byte_lsb(8'hA5, 1'b0);
    check_all("stall_first", 8'hA5, 8'hA5, 1'b1, 4'd0, 1'b0);
    send_byte_lsb(8'h3C, 1'b0);
    check_all("stall_full", 8'hA5, 8'hA5, 1'b1, 4'd8, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_all("stall_drop", 8'hA5, 8'hA5, 1'b1, 4'd8, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("stall_release", 8'h3C, 8'h3C, 1'b1, 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_all("stall_hold", 8'h3C, 8'h3C, 1'b1, 4'd0, 1'b1);

    // Release from STALL coinciding with a new bit.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte_lsb(8'h55, 1'b0);
    send_byte_lsb(8'hAA, 1'b0);
    check_all("s4_full", 8'h55, 8'hAA, 1'b1, 4'd8, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("s4_release_bit", 8'hAA, 8'h55, 1'b1, 4'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("s4_accepted.vld", 32'(if0.word_vld), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check_all("s4_word", 8'h01, 8'h80, 1'b1, 4'd0, 1'b0);

    // Asynchronous reset part-way through a word.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("s5_partial.cnt", 32'(if0.bit_cnt), 32'd5);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("s5_async", 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("s5_restart", 8'h00, 8'h00, 1'b0, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("s5_word", 8'hFF, 8'hFF, 1'b1, 4'd0, 1'b0);

    // Overrun then synchronous clear with a competing bit.
    send_byte_lsb(8'h0F, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("s6_ovr_set", 32'(if0.overrun), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check_all("s6_clr", 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_all("s6_after", 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);

    // Random traffic in blocks of differing consumer readiness.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    model_clear();
    for (int blk = 0; blk < 15; blk++) begin
      rdy_pct = (blk % 3 == 0) ? 15 : (blk % 3 == 1) ? 55 : 95;
      for (int i = 0; i < 200; i++) begin
        rv = ($urandom_range(99) < 70);
        rb = 1'($urandom);
        rr = ($urandom_range(99) < rdy_pct);
        rc = ($urandom_range(149) == 0);
        cyc(rv, rb, rr, rc);
        model_step(rv, rb, rr, rc);
        check_all($sformatf("rnd%0d_%0d", blk, i), m_w0, m_w1, m_vld, 4'(mq.size()), m_ovr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
